// File: rtl/am_insertion.sv
// Alignment-marker insertion for two 257b scrambled flows: packs block pairs into
// 10280-bit words and maps an 8-lane AM group into the low bits of every AM_PERIOD-th word.
module am_insertion #(
  parameter int BITS_BLOCK      = 257,
  parameter int AM_MAPPED_WIDTH = 10280,
  parameter int AM_WIDTH        = 1028,
  parameter int AM_PERIOD       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [BITS_BLOCK-1:0]      flow_0,
  input  logic [BITS_BLOCK-1:0]      flow_1,
  output logic [AM_MAPPED_WIDTH-1:0] tx_scrambled_f0,
  output logic [AM_MAPPED_WIDTH-1:0] tx_scrambled_f1,
  output logic                       valid_signal
);

  localparam int DATA_BLOCKS = AM_MAPPED_WIDTH / BITS_BLOCK;
  localparam int AM_BLOCKS   = (AM_MAPPED_WIDTH - AM_WIDTH) / BITS_BLOCK;
  localparam int BCNT_W      = $clog2(DATA_BLOCKS);
  localparam int WCNT_W      = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;

  // Lane k occupies bits [120k+119:120k] as 15 bytes of 8'hC0|k; the pad above stays 0.
  function automatic logic [AM_WIDTH-1:0] build_am_group();
    logic [AM_WIDTH-1:0] g;
    g = '0;
    for (int k = 0; k < 8; k++) begin
      for (int b = 0; b < 15; b++) begin
        g[120*k + 8*b +: 8] = 8'hC0 | 8'(k);
      end
    end
    return g;
  endfunction

  localparam logic [AM_WIDTH-1:0] AM_GROUP = build_am_group();

  // i_valid is a one-cycle strobe with no backpressure: each high cycle delivers one
  // flow_0/flow_1 pair; valid_signal is a one-cycle pulse and the words hold until the next.
  logic [BCNT_W-1:0]          bcnt;
  logic [WCNT_W-1:0]          wcnt;
  logic [AM_MAPPED_WIDTH-1:0] acc0;
  logic [AM_MAPPED_WIDTH-1:0] acc1;
  logic [AM_MAPPED_WIDTH-1:0] shift0;
  logic [AM_MAPPED_WIDTH-1:0] shift1;
  logic                       am_word;
  logic                       last_block;
  logic                       word_done;

  // Blocks enter at the top and move down, so after a full word block 0 sits lowest.
  // An AM word stops 4 slots early, leaving the bottom slots free for the AM group.
  assign shift0     = {flow_0, acc0[AM_MAPPED_WIDTH-1:BITS_BLOCK]};
  assign shift1     = {flow_1, acc1[AM_MAPPED_WIDTH-1:BITS_BLOCK]};
  assign am_word    = (wcnt == '0);
  assign last_block = am_word ? (bcnt == BCNT_W'(AM_BLOCKS - 1))
                              : (bcnt == BCNT_W'(DATA_BLOCKS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt            <= '0;
      wcnt            <= '0;
      acc0            <= '0;
      acc1            <= '0;
      word_done       <= 1'b0;
      valid_signal    <= 1'b0;
      tx_scrambled_f0 <= '0;
      tx_scrambled_f1 <= '0;
    end else begin
      valid_signal <= word_done;
      word_done    <= 1'b0;
      if (word_done) begin
        tx_scrambled_f0 <= acc0;
        tx_scrambled_f1 <= acc1;
      end
      if (i_valid) begin
        acc0 <= shift0;
        acc1 <= shift1;
        if (last_block) begin
          if (am_word) begin
            acc0[AM_WIDTH-1:0] <= AM_GROUP;
            acc1[AM_WIDTH-1:0] <= AM_GROUP;
          end
          bcnt      <= '0;
          wcnt      <= (wcnt == WCNT_W'(AM_PERIOD - 1)) ? '0 : wcnt + WCNT_W'(1);
          word_done <= 1'b1;
        end else begin
          bcnt <= bcnt + BCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_am_insertion.sv
// Scoreboard bench for am_insertion: a block-list reference model builds expected words,
// a negedge monitor checks every valid_signal pulse, its latency and output hold.
module tb_am_insertion;

  localparam int B      = 257;
  localparam int W      = 10280;
  localparam int AMW    = 1028;
  localparam int PERIOD = 4;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic [B-1:0] flow_0;
  logic [B-1:0] flow_1;
  logic [W-1:0] tx0;
  logic [W-1:0] tx1;
  logic         valid_signal;

  am_insertion #(
    .BITS_BLOCK(B), .AM_MAPPED_WIDTH(W), .AM_WIDTH(AMW), .AM_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst_n), .i_valid(i_valid), .flow_0(flow_0), .flow_1(flow_1),
    .tx_scrambled_f0(tx0), .tx_scrambled_f1(tx1), .valid_signal(valid_signal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int           exp_cyc_q[$];
  logic [B-1:0] blk0[$];
  logic [B-1:0] blk1[$];
  int           m_wcnt = 0;
  logic [AMW-1:0] am_ref;
  logic [W-1:0] held0, held1;

  task automatic cmp_word(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      int k;
      bad++;
      k = 0;
      for (int s = 39; s >= 0; s--) if (got[s*B +: B] !== exp[s*B +: B]) k = s;
      $display("FAIL %s cycle %0d first bad slot %0d got %h exp %h",
               name, cyc, k, got[k*B +: B], exp[k*B +: B]);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle %0d got %0d exp %0d", name, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void build_am_ref();
    logic [7:0] bt;
    am_ref = '0;
    for (int k = 0; k < 8; k++) begin
      bt = 8'hC0 + 8'(k);
      am_ref[120*k +: 120] = {15{bt}};
    end
  endfunction

  function automatic void model_block(input logic [B-1:0] f0, input logic [B-1:0] f1, input int cap);
    int need;
    logic [W-1:0] w0, w1;
    blk0.push_back(f0);
    blk1.push_back(f1);
    need = (m_wcnt == 0) ? 36 : 40;
    if (blk0.size() == need) begin
      w0 = '0;
      w1 = '0;
      if (m_wcnt == 0) begin
        w0[AMW-1:0] = am_ref;
        w1[AMW-1:0] = am_ref;
        for (int j = 0; j < 36; j++) begin
          w0[AMW + B*j +: B] = blk0[j];
          w1[AMW + B*j +: B] = blk1[j];
        end
      end else begin
        for (int i = 0; i < 40; i++) begin
          w0[B*i +: B] = blk0[i];
          w1[B*i +: B] = blk1[i];
        end
      end
      exp0_q.push_back(w0);
      exp1_q.push_back(w1);
      exp_cyc_q.push_back(cap + 1);
      blk0.delete();
      blk1.delete();
      m_wcnt = (m_wcnt + 1) % PERIOD;
    end
  endfunction

  function automatic void model_reset();
    blk0.delete();
    blk1.delete();
    m_wcnt = 0;
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [B-1:0] f0, input logic [B-1:0] f1);
    i_valid = 1'b1;
    flow_0  = f0;
    flow_1  = f1;
    @(posedge clk);
    #1;
    model_block(f0, f1, cyc);
    i_valid = 1'b0;
    flow_0  = {B{1'bx}};
    flow_1  = {B{1'bx}};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [B-1:0] rand_blk();
    logic [B-1:0] v;
    for (int i = 0; i < B; i += 32) v[i +: 32] = 32'($urandom);
    return v;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp0_q.size() != 0; i++) idle(1);
    cmp_int("drain_pending_words", exp0_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      cmp_int("reset_valid", int'(valid_signal), 0);
      cmp_word("reset_f0", tx0, '0);
      cmp_word("reset_f1", tx1, '0);
      held0 = '0;
      held1 = '0;
    end else if (valid_signal) begin
      if (exp0_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse cycle %0d", cyc);
      end else begin
        cmp_word("word_f0", tx0, exp0_q.pop_front());
        cmp_word("word_f1", tx1, exp1_q.pop_front());
        cmp_int("pulse_latency", cyc, exp_cyc_q.pop_front());
      end
      held0 = tx0;
      held1 = tx1;
    end else begin
      cmp_word("hold_f0", tx0, held0);
      cmp_word("hold_f1", tx1, held1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    flow_0  = '0;
    flow_1  = '0;
    build_am_ref();
    idle(4);
    rst_n = 1'b1;
    idle(2);

    // AM word: flow 0 all ones, flow 1 zero
    for (int i = 0; i < 36; i++) send({B{1'b1}}, '0);
    // three data words carrying their block index in flow 0
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < 40; i++) send(B'(i), rand_blk());
    // fifth word wraps back to AM
    for (int i = 0; i < 36; i++) send(rand_blk(), rand_blk());
    wait_drain();

    // random gaps, including back-to-back and strobes during pulses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
      send(rand_blk(), rand_blk());
    end
    // advance to the start of a data word, then reset 20 blocks into it
    for (int n = 0; n < 200 && !(m_wcnt == 1 && blk0.size() == 0); n++) send(rand_blk(), rand_blk());
    wait_drain();
    for (int i = 0; i < 20; i++) send(rand_blk(), rand_blk());
    #2;
    rst_n = 1'b0;
    #1;
    cmp_word("async_reset_f0", tx0, '0);
    cmp_word("async_reset_f1", tx1, '0);
    cmp_int("async_reset_valid", int'(valid_signal), 0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 1) != 0) idle(1);
      send(rand_blk(), rand_blk());
    end
    wait_drain();
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
